tx_safety_ramp: RTL and testbench
=================================

TX_SAFETY_RAMP -- requirements
Module: tx_safety_ramp

Interface
REQ-001 Parameter AMP_W, default 16, amplitude word width.
REQ-002 Parameter RAMP_STEP, default 256, amplitude change per ramp tick.
REQ-003 Parameter TICK_DIV, default 100, clk cycles per ramp tick (>=1).
REQ-004 clk  input  1  clock, all logic on rising edge.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 rf_req  input  1  host request to radiate, level.
REQ-007 amp_target  input  AMP_W  requested carrier amplitude, unsigned.
REQ-008 wd_triggered  input  1  watchdog timeout, level.
REQ-009 wd_warning  input  1  watchdog pre-timeout warning, level.
REQ-010 fault_clear  input  1  host fault acknowledge, single-cycle pulse.
REQ-011 amp_out  output  AMP_W  amplitude to modulator, registered.
REQ-012 rf_on  output  1  high in RAMP_UP, ON and RAMP_DOWN.
REQ-013 fault_latched  output  1  sticky watchdog fault flag, registered.
REQ-014 state  output  3  FSM state encoding.

Function
REQ-015 States SHALL be IDLE=0, RAMP_UP=1, ON=2, RAMP_DOWN=3, FAULT=4; other codes SHALL go to IDLE next cycle.
REQ-016 IDLE: amp_out=0; rf_req=1, fault_latched=0 and wd_triggered=0 SHALL go to RAMP_UP and capture amp_target into amp_tgt_q.
REQ-017 amp_target changes outside IDLE SHALL be ignored until the next IDLE->RAMP_UP transition.
REQ-018 A prescaler SHALL reset to 0 on every state entry and produce a one-cycle tick when its count reaches TICK_DIV-1 in RAMP_UP or RAMP_DOWN, then wrap to 0.
REQ-019 RAMP_UP: on each tick, amp_out <= min(amp_out+RAMP_STEP, amp_tgt_q) using AMP_W+1-bit arithmetic with no wrap; at amp_out==amp_tgt_q the FSM SHALL enter ON.
REQ-020 amp_tgt_q==0 SHALL pass RAMP_UP->ON on the first tick.
REQ-021 ON: amp_out=amp_tgt_q; rf_req=0 SHALL go to RAMP_DOWN.
REQ-022 RAMP_DOWN: on each tick, amp_out <= max(amp_out-RAMP_STEP, 0) with no underflow; at 0, go to FAULT if fault_latched else IDLE.
REQ-023 rf_req=0 in RAMP_UP SHALL go to RAMP_DOWN, starting from the current amp_out.
REQ-024 wd_triggered=1 in any state SHALL set fault_latched next cycle; in RAMP_UP or ON it SHALL force RAMP_DOWN next cycle, with priority over rf_req.
REQ-025 wd_triggered=1 in IDLE SHALL go to FAULT.
REQ-026 FAULT: amp_out=0; fault_clear=1 with wd_triggered=0 SHALL clear fault_latched and go to IDLE next cycle; fault_clear SHALL be ignored in all other states and while wd_triggered=1.
REQ-027 rf_req held high after fault clear SHALL re-enter RAMP_UP only after one IDLE cycle.

Reset
REQ-028 rstn=0 SHALL set state=IDLE, amp_out=0, rf_on=0, fault_latched=0, prescaler=0, amp_tgt_q=0 on the next edge, overriding all inputs including mid-ramp.

Configuration
REQ-029 With SAFETY_WARN_ATTEN_EN defined, ON with wd_warning=1 SHALL drive amp_out=amp_tgt_q>>1 next cycle and restore amp_tgt_q the cycle after wd_warning falls.
REQ-030 Without SAFETY_WARN_ATTEN_EN, wd_warning SHALL have no effect and SHALL be left unconnected internally.

Structure
REQ-031 Package tx_safety_pkg SHALL hold the state enum and the default AMP_W, RAMP_STEP and TICK_DIV constants.
REQ-032 The prescaler SHALL be sub-module ramp_tick_gen with inputs clk, rstn, clr, run and output tick.

Verification (TICK_DIV=4, RAMP_STEP=256)
REQ-033 rf_req=1, amp_target=1024 -> RAMP_UP; amp_out steps 256/512/768/1024 every 4 cycles; ON on cycle 17.
REQ-034 ON at 1024, rf_req=0 -> RAMP_DOWN to 0 in 4 ticks -> IDLE, fault_latched=0.
REQ-035 ON at 1024, wd_triggered=1 -> fault_latched=1 next cycle, ramp to 0, FAULT; fault_clear during wd_triggered=1 ignored; fault_clear after it drops -> IDLE.
REQ-036 amp_target=300 -> amp_out 256 then 300 (saturated), ON; target changed to 5000 in ON -> amp_out stays 300.
REQ-037 rstn=0 mid-RAMP_UP at amp_out=512 -> amp_out=0, IDLE next cycle.
REQ-038 SAFETY_WARN_ATTEN_EN, ON at 1024, wd_warning=1 for 3 cycles -> amp_out=512 for 3 cycles, then 1024.

Source files
------------

// File: rtl/tx_safety_pkg.sv
// +-----------------------------------------------------------------------------
// | Module   : tx_safety_pkg
// | Brief    : State encoding and default sizing for the TX safety ramp.
// | Revision : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

package tx_safety_pkg;

    localparam int unsigned AMP_W_DEF     = 16;
    localparam int unsigned RAMP_STEP_DEF = 256;
    localparam int unsigned TICK_DIV_DEF  = 100;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_ON        = 3'd2,
        ST_RAMP_DOWN = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/ramp_tick_gen.sv
// +-----------------------------------------------------------------------------
// | Module   : ramp_tick_gen
// | Brief    : Prescaler producing a one-cycle tick every TICK_DIV running cycles.
// | Revision : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module ramp_tick_gen
    import tx_safety_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int unsigned         c_cnt_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_cnt_w-1:0]  c_last  = c_cnt_w'(TICK_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               w_wrap;

    assign w_wrap = (r_cnt == c_last);
    assign tick   = run && w_wrap;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/tx_safety_ramp.sv
// +-----------------------------------------------------------------------------
// | Module   : tx_safety_ramp
// | Brief    : Carrier amplitude ramp FSM with sticky watchdog fault handling.
// |            Optional macro SAFETY_WARN_ATTEN_EN halves amplitude in ON while
// |            the watchdog warning is asserted.
// | Revision : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module tx_safety_ramp
    import tx_safety_pkg::*;
#(
    parameter int unsigned AMP_W     = AMP_W_DEF,
    parameter int unsigned RAMP_STEP = RAMP_STEP_DEF,
    parameter int unsigned TICK_DIV  = TICK_DIV_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             rf_req,
    input  logic [AMP_W-1:0] amp_target,
    input  logic             wd_triggered,
    input  logic             wd_warning,
    input  logic             fault_clear,
    output logic [AMP_W-1:0] amp_out,
    output logic             rf_on,
    output logic             fault_latched,
    output logic [2:0]       state
);

    localparam logic [AMP_W:0] c_step = (AMP_W + 1)'(RAMP_STEP);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [AMP_W-1:0] r_amp;
    logic [AMP_W-1:0] w_amp_nxt;
    logic [AMP_W-1:0] r_tgt;
    logic [AMP_W-1:0] w_tgt_nxt;
    logic             r_fault;
    logic             w_fault_nxt;
    logic             w_tick;
    logic             w_clr;
    logic             w_run;
    logic [AMP_W:0]   w_sum;
    logic [AMP_W-1:0] w_amp_up;
    logic [AMP_W-1:0] w_amp_dn;
    logic [AMP_W-1:0] w_on_amp;

    // Extra bit on the sum keeps saturation correct near full scale.
    assign w_sum    = {1'b0, r_amp} + c_step;
    assign w_amp_up = (w_sum >= {1'b0, r_tgt}) ? r_tgt : w_sum[AMP_W-1:0];
    assign w_amp_dn = ({1'b0, r_amp} <= c_step) ? '0 : r_amp - c_step[AMP_W-1:0];

`ifdef SAFETY_WARN_ATTEN_EN
    assign w_on_amp = wd_warning ? (r_tgt >> 1) : r_tgt;
`else
    logic w_unused_warn;
    assign w_unused_warn = wd_warning;
    assign w_on_amp      = r_tgt;
`endif

    assign w_run = (r_state == ST_RAMP_UP) || (r_state == ST_RAMP_DOWN);
    assign w_clr = (w_state_nxt != r_state);

    ramp_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rstn (rstn),
        .clr  (w_clr),
        .run  (w_run),
        .tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_amp   <= '0;
            r_tgt   <= '0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_amp   <= w_amp_nxt;
            r_tgt   <= w_tgt_nxt;
            r_fault <= w_fault_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_amp_nxt   = r_amp;
        w_tgt_nxt   = r_tgt;
        w_fault_nxt = r_fault | wd_triggered;
        case (r_state)
            ST_IDLE: begin
                w_amp_nxt = '0;
                if (wd_triggered || r_fault) begin
                    w_state_nxt = ST_FAULT;
                end else if (rf_req) begin
                    w_state_nxt = ST_RAMP_UP;
                    w_tgt_nxt   = amp_target;
                end
            end
            ST_RAMP_UP: begin
                // Aborts hold the current amplitude as the ramp-down start point.
                if (wd_triggered || !rf_req) begin
                    w_state_nxt = ST_RAMP_DOWN;
                end else if (w_tick) begin
                    w_amp_nxt = w_amp_up;
                    if (w_amp_up == r_tgt) begin
                        w_state_nxt = ST_ON;
                    end
                end
            end
            ST_ON: begin
                if (wd_triggered || !rf_req) begin
                    w_state_nxt = ST_RAMP_DOWN;
                end else begin
                    w_amp_nxt = w_on_amp;
                end
            end
            ST_RAMP_DOWN: begin
                if (w_tick) begin
                    w_amp_nxt = w_amp_dn;
                    if (w_amp_dn == '0) begin
                        w_state_nxt = w_fault_nxt ? ST_FAULT : ST_IDLE;
                    end
                end
            end
            ST_FAULT: begin
                w_amp_nxt = '0;
                if (fault_clear && !wd_triggered) begin
                    w_fault_nxt = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_amp_nxt   = '0;
            end
        endcase
    end

    assign amp_out       = r_amp;
    assign fault_latched = r_fault;
    assign state         = r_state;
    assign rf_on         = (r_state == ST_RAMP_UP) || (r_state == ST_ON) ||
                           (r_state == ST_RAMP_DOWN);

endmodule

`default_nettype wire

// File: tb/tb_tx_safety_ramp.sv
// +-----------------------------------------------------------------------------
// | Module   : tb_tx_safety_ramp
// | Brief    : Directed and random checks of tx_safety_ramp against a behavioural model.
// | Revision : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_tx_safety_ramp;

    localparam int AMP_W = 16;
    localparam int STEP  = 256;
    localparam int TDIV  = 4;
    localparam int S_IDLE = 0, S_UP = 1, S_ON = 2, S_DOWN = 3, S_FAULT = 4;
`ifdef SAFETY_WARN_ATTEN_EN
    localparam bit WARN_EN = 1'b1;
`else
    localparam bit WARN_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rstn, rf_req, wd_triggered, wd_warning, fault_clear;
    logic [AMP_W-1:0] amp_target;
    logic [AMP_W-1:0] amp_out;
    logic             rf_on, fault_latched;
    logic [2:0]       state;
    logic [20:0]      act_vec;

    int vectors     = 0;
    int miscompares = 0;

    // Model: mode, amplitude, captured target, fault flag, cycles spent in current mode.
    int m_state = S_IDLE, m_amp = 0, m_tgt = 0, m_age = 0;
    bit m_fault = 1'b0;

    tx_safety_ramp #(
        .AMP_W     (AMP_W),
        .RAMP_STEP (STEP),
        .TICK_DIV  (TDIV)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .rf_req        (rf_req),
        .amp_target    (amp_target),
        .wd_triggered  (wd_triggered),
        .wd_warning    (wd_warning),
        .fault_clear   (fault_clear),
        .amp_out       (amp_out),
        .rf_on         (rf_on),
        .fault_latched (fault_latched),
        .state         (state)
    );

    always #5 clk = ~clk;

    assign act_vec = {state, amp_out, rf_on, fault_latched};

    function automatic logic [20:0] exp_vec();
        return {3'(m_state), 16'(m_amp), (m_state >= S_UP && m_state <= S_DOWN), m_fault};
    endfunction

    task automatic model_step();
        int n_state = m_state;
        int n_amp   = m_amp;
        int n_tgt   = m_tgt;
        bit n_fault = m_fault | wd_triggered;
        bit tk      = (m_state == S_UP || m_state == S_DOWN) && ((m_age % TDIV) == TDIV - 1);
        if (!rstn) begin
            n_state = S_IDLE; n_amp = 0; n_tgt = 0; n_fault = 1'b0;
        end else begin
            case (m_state)
                S_IDLE: begin
                    n_amp = 0;
                    if (wd_triggered || m_fault) n_state = S_FAULT;
                    else if (rf_req) begin n_state = S_UP; n_tgt = int'(amp_target); end
                end
                S_UP: begin
                    if (wd_triggered || !rf_req) n_state = S_DOWN;
                    else if (tk) begin
                        n_amp = (m_amp + STEP < m_tgt) ? m_amp + STEP : m_tgt;
                        if (n_amp == m_tgt) n_state = S_ON;
                    end
                end
                S_ON: begin
                    if (wd_triggered || !rf_req) n_state = S_DOWN;
                    else n_amp = (WARN_EN && wd_warning) ? m_tgt / 2 : m_tgt;
                end
                S_DOWN: begin
                    if (tk) begin
                        n_amp = (m_amp > STEP) ? m_amp - STEP : 0;
                        if (n_amp == 0) n_state = n_fault ? S_FAULT : S_IDLE;
                    end
                end
                default: begin
                    n_amp = 0;
                    if (fault_clear && !wd_triggered) begin n_fault = 1'b0; n_state = S_IDLE; end
                end
            endcase
        end
        m_age   = (!rstn || n_state != m_state) ? 0 : m_age + 1;
        m_state = n_state; m_amp = n_amp; m_tgt = n_tgt; m_fault = n_fault;
    endtask

    task automatic clk_step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; rf_req = 1'b0; wd_triggered = 1'b0; wd_warning = 1'b0;
        fault_clear = 1'b0; amp_target = '0;
        clk_step();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        clk_step();
        vectors++;
        if (state !== 3'd0 || amp_out !== 16'd0 || rf_on !== 1'b0 || fault_latched !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: got state=%0d amp=%0d rf_on=%0b fault=%0b, expected 0/0/0/0",
                     state, amp_out, rf_on, fault_latched);
        end
    endtask

    task automatic test_ramp_up();
        rf_req = 1'b1; amp_target = 16'd1024;
        for (int k = 1; k <= 17; k++) begin
            clk_step();
            vectors++;
            if (amp_out !== 16'(((k - 1) / 4) * 256) || state !== ((k == 17) ? 3'd2 : 3'd1)) begin
                miscompares++;
                $display("FAIL ramp_up cyc %0d: got amp=%0d state=%0d", k, amp_out, state);
            end
            vectors++;
            if (act_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL ramp_up_model cyc %0d: got %h expected %h", k, act_vec, exp_vec());
            end
        end
    endtask

    task automatic test_ramp_down();
        rf_req = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            clk_step();
            vectors++;
            if (amp_out !== 16'(1024 - ((k - 1) / 4) * 256) ||
                state !== ((k == 17) ? 3'd0 : 3'd3) || fault_latched !== 1'b0) begin
                miscompares++;
                $display("FAIL ramp_down cyc %0d: got amp=%0d state=%0d fault=%0b",
                         k, amp_out, state, fault_latched);
            end
        end
    endtask

    task automatic test_watchdog();
        rf_req = 1'b1; amp_target = 16'd1024;
        for (int k = 0; k < 17; k++) clk_step();
        wd_triggered = 1'b1;
        clk_step();
        vectors++;
        if (fault_latched !== 1'b1 || state !== 3'd3 || amp_out !== 16'd1024) begin
            miscompares++;
            $display("FAIL wd_force_down: got fault=%0b state=%0d amp=%0d, expected 1/3/1024",
                     fault_latched, state, amp_out);
        end
        for (int k = 2; k <= 17; k++) begin
            clk_step();
            vectors++;
            if (act_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL wd_ramp cyc %0d: got %h expected %h", k, act_vec, exp_vec());
            end
        end
        vectors++;
        if (state !== 3'd4 || amp_out !== 16'd0) begin
            miscompares++;
            $display("FAIL wd_fault_entry: got state=%0d amp=%0d, expected 4/0", state, amp_out);
        end
        fault_clear = 1'b1;
        clk_step();
        fault_clear = 1'b0; wd_triggered = 1'b0;
        clk_step();
        vectors++;
        if (state !== 3'd4 || fault_latched !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_ignored: got state=%0d fault=%0b, expected 4/1", state, fault_latched);
        end
        fault_clear = 1'b1;
        clk_step();
        fault_clear = 1'b0;
        vectors++;
        if (state !== 3'd0 || fault_latched !== 1'b0) begin
            miscompares++;
            $display("FAIL fault_clear: got state=%0d fault=%0b, expected 0/0", state, fault_latched);
        end
        clk_step();
        vectors++;
        if (state !== 3'd1) begin
            miscompares++;
            $display("FAIL reenter_after_idle: got state=%0d, expected 1", state);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        rf_req = 1'b1; amp_target = 16'd300;
        for (int k = 1; k <= 9; k++) begin
            clk_step();
            if (k == 5) begin
                vectors++;
                if (amp_out !== 16'd256) begin
                    miscompares++;
                    $display("FAIL sat_first_step: got amp=%0d, expected 256", amp_out);
                end
            end
        end
        vectors++;
        if (amp_out !== 16'd300 || state !== 3'd2) begin
            miscompares++;
            $display("FAIL sat_on: got amp=%0d state=%0d, expected 300/2", amp_out, state);
        end
        amp_target = 16'd5000;
        for (int k = 0; k < 6; k++) clk_step();
        vectors++;
        if (amp_out !== 16'd300 || state !== 3'd2) begin
            miscompares++;
            $display("FAIL target_ignored: got amp=%0d state=%0d, expected 300/2", amp_out, state);
        end
    endtask

    task automatic test_zero_target();
        do_reset();
        rf_req = 1'b1; amp_target = 16'd0;
        for (int k = 1; k <= 5; k++) begin
            clk_step();
            vectors++;
            if (state !== ((k == 5) ? 3'd2 : 3'd1) || amp_out !== 16'd0) begin
                miscompares++;
                $display("FAIL zero_target cyc %0d: got state=%0d amp=%0d", k, state, amp_out);
            end
        end
    endtask

    task automatic test_reset_mid_ramp();
        do_reset();
        rf_req = 1'b1; amp_target = 16'd1024;
        for (int k = 0; k < 9; k++) clk_step();
        vectors++;
        if (amp_out !== 16'd512) begin
            miscompares++;
            $display("FAIL mid_ramp_level: got amp=%0d, expected 512", amp_out);
        end
        rstn = 1'b0;
        clk_step();
        rstn = 1'b1; rf_req = 1'b0;
        vectors++;
        if (amp_out !== 16'd0 || state !== 3'd0 || rf_on !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_ramp_reset: got amp=%0d state=%0d rf_on=%0b, expected 0/0/0",
                     amp_out, state, rf_on);
        end
    endtask

    task automatic test_abort_ramp_up();
        do_reset();
        rf_req = 1'b1; amp_target = 16'd2000;
        for (int k = 0; k < 10; k++) clk_step();
        rf_req = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            clk_step();
            vectors++;
            if (act_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL abort_up cyc %0d: got %h expected %h", k, act_vec, exp_vec());
            end
        end
    endtask

    task automatic test_warning();
        do_reset();
        rf_req = 1'b1; amp_target = 16'd1024;
        for (int k = 0; k < 17; k++) clk_step();
        wd_warning = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            clk_step();
            vectors++;
            if (amp_out !== (WARN_EN ? 16'd512 : 16'd1024) || state !== 3'd2) begin
                miscompares++;
                $display("FAIL warn_atten cyc %0d: got amp=%0d state=%0d", k, amp_out, state);
            end
        end
        wd_warning = 1'b0;
        clk_step();
        vectors++;
        if (amp_out !== 16'd1024) begin
            miscompares++;
            $display("FAIL warn_restore: got amp=%0d, expected 1024", amp_out);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            rstn = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 39) == 0) rf_req = ~rf_req;
            if ($urandom_range(0, 9) == 0)
                amp_target = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 3000));
            if (wd_triggered) wd_triggered = ($urandom_range(0, 5) != 0);
            else              wd_triggered = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 5) == 0) wd_warning = ~wd_warning;
            fault_clear = ($urandom_range(0, 15) == 0);
            clk_step();
            vectors++;
            if (act_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL random cyc %0d: got %h expected %h", c, act_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_watchdog();
        test_saturate();
        test_zero_target();
        test_reset_mid_ramp();
        test_abort_ramp_up();
        test_warning();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
